// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the iterative CORDIC engine.
//   - FSM state encodings (ST_*) and the mode encodings (MODE_ROT / MODE_VEC).
//   - K (CORDIC gain compensation) and pi as signed Q3.61 constants.
//   - 32-entry atan(2^-i) table in signed Q3.61.
// Q3.61 -> Q3.(W-3) is an arithmetic right shift by 64-W. For a 64-bit value
// that is the same as taking its top W bits, so users take [63 -: W].
// -----------------------------------------------------------------------------
package cordic_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_ITER = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // 2^61, exactly representable as a double.
    localparam real Q61_SCALE = 2305843009213693952.0;

    // Elaboration-time conversion of a real constant to Q3.61 (rounded).
    function automatic logic signed [63:0] to_q61(input real r);
        return longint'(r * Q61_SCALE);
    endfunction

    // For small angles atan(x) = x - x^3/3 + x^5/5 is exact to double precision.
    function automatic real atan_small(input int i);
        real x;
        x = 1.0 / (2.0 ** i);
        return x - (x * x * x) / 3.0 + (x * x * x * x * x) / 5.0;
    endfunction

    localparam logic signed [63:0] K_Q61  = to_q61(0.6072529350088812561694);
    localparam logic signed [63:0] PI_Q61 = to_q61(3.1415926535897932384626);

    localparam logic signed [63:0] ATAN_Q61 [32] = '{
        to_q61(0.78539816339744830962), to_q61(0.46364760900080611621),
        to_q61(0.24497866312686415417), to_q61(0.12435499454676143503),
        to_q61(0.06241880999595734847), to_q61(0.03123983343026827625),
        to_q61(0.01562372862047683081), to_q61(0.00781234106010111130),
        to_q61(0.00390623013196697182), to_q61(0.00195312251647881868),
        to_q61(0.00097656218955931943), to_q61(0.00048828121119489829),
        to_q61(0.00024414062014936177), to_q61(0.00012207031189367021),
        to_q61(0.00006103515617420877), to_q61(0.00003051757811552610),
        to_q61(0.00001525878906131576), to_q61(atan_small(17)),
        to_q61(atan_small(18)),         to_q61(atan_small(19)),
        to_q61(atan_small(20)),         to_q61(atan_small(21)),
        to_q61(atan_small(22)),         to_q61(atan_small(23)),
        to_q61(atan_small(24)),         to_q61(atan_small(25)),
        to_q61(atan_small(26)),         to_q61(atan_small(27)),
        to_q61(atan_small(28)),         to_q61(atan_small(29)),
        to_q61(atan_small(30)),         to_q61(atan_small(31))
    };

endpackage

// File: rtl/cordic_atan_lut.sv
// -----------------------------------------------------------------------------
// cordic_atan_lut
// Combinational arctangent lookup: angle = atan(2^-idx) in Q3.(W-3).
//   idx   in  5  micro-rotation index 0..31
//   angle out W  signed angle in radians, truncated from the Q3.61 table
// -----------------------------------------------------------------------------
module cordic_atan_lut
    import cordic_pkg::*;
#(
    parameter int W = 32
) (
    input  logic        [4:0]   idx,
    output logic signed [W-1:0] angle
);

    // Top W bits of a Q3.61 word == arithmetic shift right by 61-(W-3).
    assign angle = ATAN_Q61[idx][63 -: W];

endmodule

// File: rtl/cordic_iter_engine.sv
// -----------------------------------------------------------------------------
// cordic_iter_engine
// Iterative fixed-point CORDIC, one micro-rotation per clock.
// Rotation mode: cos/sin of z_in. Vectoring mode: An*|(x,y)| and atan2(y,x).
// Data are signed Q3.(W-3).
//   clk, rst              clock; synchronous active-low reset
//   beg_cordic            start request (sampled in IDLE only)
//   ack_cordic            result consumed (sampled in DONE only)
//   mode                  0 rotation, 1 vectoring (latched in LOAD)
//   shift_region_flag     rotation: bit0 negates x_out, bit1 negates y_out
//   x_in, y_in, z_in      operands
//   ready_cordic          high in DONE until ack
//   busy                  high in LOAD, ITER, POST
//   x_out, y_out, z_out   registered results, held until the next POST
// -----------------------------------------------------------------------------
module cordic_iter_engine
    import cordic_pkg::*;
#(
    parameter int W    = 32,
    parameter int ITER = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         beg_cordic,
    input  logic         ack_cordic,
    input  logic         mode,
    input  logic [1:0]   shift_region_flag,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    input  logic [W-1:0] z_in,
    output logic         ready_cordic,
    output logic         busy,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic [W-1:0] z_out
);

    localparam int FRAC  = W - 3;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
    localparam logic signed [W-1:0] K_W  = K_Q61[63 -: W];
    localparam logic signed [W-1:0] PI_W = PI_Q61[63 -: W];

    // Shift amounts beyond FRAC would only ever add zero, and the table has 32 entries.
    if (ITER < 4 || ITER > FRAC || ITER > 32 || W < 8 || W > 64) begin : g_param_check
        $error("cordic_iter_engine: illegal parameters W=%0d ITER=%0d", W, ITER);
    end

    logic [2:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    mode_q, mode_d;
    logic [1:0]              flag_q, flag_d;
    logic signed [W-1:0]     x_q, x_d, y_q, y_d, z_q, z_d;
    logic [W-1:0]            x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;

    logic signed [W-1:0]     x_in_s, y_in_s, x_sh, y_sh, atan_i;
    logic [4:0]              lut_idx;
    logic                    d_pos;

    assign x_in_s  = x_in;
    assign y_in_s  = y_in;
    assign lut_idx = 5'(cnt_q);
    assign x_sh    = x_q >>> cnt_q;
    assign y_sh    = y_q >>> cnt_q;

    // Rotation drives z to 0; vectoring drives y to 0.
    assign d_pos = (mode_q == MODE_ROT) ? ~z_q[W-1] : y_q[W-1];

    cordic_atan_lut #(.W(W)) u_atan_lut (
        .idx   (lut_idx),
        .angle (atan_i)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        flag_d   = flag_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        x_out_d  = x_out_q;
        y_out_d  = y_out_q;
        z_out_d  = z_out_q;
        case (state_q)
            ST_IDLE: begin
                if (beg_cordic) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                mode_d = mode;
                flag_d = shift_region_flag;
                cnt_d  = '0;
                if (mode == MODE_ROT) begin
                    x_d = K_W;
                    y_d = '0;
                    z_d = z_in;
                end else if (!x_in_s[W-1]) begin
                    x_d = x_in_s;
                    y_d = y_in_s;
                    z_d = '0;
                end else begin
                    // Left half-plane: rotate by pi first so the iterations converge.
                    x_d = -x_in_s;
                    y_d = -y_in_s;
                    z_d = y_in_s[W-1] ? -PI_W : PI_W;
                end
                state_d = ST_ITER;
            end
            ST_ITER: begin
                if (d_pos) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_i;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_i;
                end
                if (cnt_q == CNT_LAST) state_d = ST_POST;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            ST_POST: begin
                if (mode_q == MODE_ROT) begin
                    x_out_d = flag_q[0] ? -x_q : x_q;
                    y_out_d = flag_q[1] ? -y_q : y_q;
                end else begin
                    x_out_d = x_q;
                    y_out_d = y_q;
                end
                z_out_d = z_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (ack_cordic) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_ROT;
            flag_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            z_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            flag_q  <= flag_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            z_out_q <= z_out_d;
        end
    end

    assign ready_cordic = (state_q == ST_DONE);
    assign busy         = (state_q == ST_LOAD) || (state_q == ST_ITER) || (state_q == ST_POST);
    assign x_out        = x_out_q;
    assign y_out        = y_out_q;
    assign z_out        = z_out_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// -----------------------------------------------------------------------------
// tb_cordic_iter_engine
// Directed bench for cordic_iter_engine: W=32/ITER=16 main instance plus
// ITER=8 and ITER=24 instances for the parameter sweep.
// -----------------------------------------------------------------------------
module tb_cordic_iter_engine;

    localparam int  W   = 32;
    localparam real ONE = 536870912.0;   // 2^29
    localparam real TOL = 1.0 / 8192.0;  // 2^-13
    localparam real PI  = 3.14159265358979;
    localparam real AN  = 1.646760258;

    logic         clk = 1'b0;
    logic         rst, beg, ack, mode;
    logic [1:0]   flag;
    logic [W-1:0] x_in, y_in, z_in;
    logic         ready, busy;
    logic [W-1:0] x_out, y_out, z_out;

    logic         s_beg, s_ack;
    logic [1:0]   s_flag;
    logic [W-1:0] s_z, s_zero;
    logic         ready8, busy8, ready24, busy24;
    logic [W-1:0] x8, y8, z8, x24, y24, z24;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cordic_iter_engine #(.W(W), .ITER(16)) dut (
        .clk(clk), .rst(rst), .beg_cordic(beg), .ack_cordic(ack), .mode(mode),
        .shift_region_flag(flag), .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .ready_cordic(ready), .busy(busy), .x_out(x_out), .y_out(y_out), .z_out(z_out)
    );

    cordic_iter_engine #(.W(W), .ITER(8)) dut8 (
        .clk(clk), .rst(rst), .beg_cordic(s_beg), .ack_cordic(s_ack), .mode(1'b0),
        .shift_region_flag(s_flag), .x_in(s_zero), .y_in(s_zero), .z_in(s_z),
        .ready_cordic(ready8), .busy(busy8), .x_out(x8), .y_out(y8), .z_out(z8)
    );

    cordic_iter_engine #(.W(W), .ITER(24)) dut24 (
        .clk(clk), .rst(rst), .beg_cordic(s_beg), .ack_cordic(s_ack), .mode(1'b0),
        .shift_region_flag(s_flag), .x_in(s_zero), .y_in(s_zero), .z_in(s_z),
        .ready_cordic(ready24), .busy(busy24), .x_out(x24), .y_out(y24), .z_out(z24)
    );

    typedef struct {
        string      name;
        logic       m;
        logic [1:0] f;
        real        x, y, z;
        real        ex, ey, ez;
        bit         cz;
    } vec_t;

    vec_t vq[$];

    function automatic logic [W-1:0] fx(input real r);
        logic [W-1:0] v;
        v = $rtoi(r * ONE);
        return v;
    endfunction

    function automatic real rl(input logic [W-1:0] v);
        return $itor($signed(v)) / ONE;
    endfunction

    task automatic add_vec(input string n, input logic m, input logic [1:0] f,
                           input real x, input real y, input real z,
                           input real ex, input real ey, input real ez, input bit cz);
        vec_t v;
        v.name = n; v.m = m; v.f = f; v.x = x; v.y = y; v.z = z;
        v.ex = ex; v.ey = ey; v.ez = ez; v.cz = cz;
        vq.push_back(v);
    endtask

    task automatic chk_near(input string n, input logic [W-1:0] act, input real exp, input real tol);
        real a;
        a = rl(act);
        total++;
        if ((a - exp) > tol || (exp - a) > tol) begin
            bad++;
            $display("FAIL %s: got %f (0x%08h) expected %f +/- %g", n, a, act, exp, tol);
        end
    endtask

    task automatic chk_int(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // Asserts beg just after edge N; returns the edge count after N at which
    // ready is first seen (-1 on timeout) and how many in-between cycles had busy low.
    // dist_c != 0 pulses beg (and clobbers z_in) at that cycle.
    task automatic run_op(input logic m, input logic [1:0] f, input logic [W-1:0] xi,
                          input logic [W-1:0] yi, input logic [W-1:0] zi, input int dist_c,
                          output int lat, output int gaps);
        lat  = -1;
        gaps = 0;
        @(posedge clk); #1;
        mode = m; flag = f; x_in = xi; y_in = yi; z_in = zi; beg = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (c == 1) beg = 1'b0;
            if (dist_c != 0 && c == dist_c) begin
                beg  = 1'b1;
                z_in = '0;
            end
            if (dist_c != 0 && c == dist_c + 1) beg = 1'b0;
            if (ready) begin
                lat = c;
                break;
            end
            if (!busy) gaps++;
        end
        $display("op mode=%0d flag=%0d lat=%0d x_out=%f y_out=%f z_out=%f",
                 m, f, lat, rl(x_out), rl(y_out), rl(z_out));
    endtask

    task automatic do_ack(input string n);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        chk_int({n, "_ack_ready"}, int'(ready), 0);
        chk_int({n, "_ack_busy"}, int'(busy), 0);
    endtask

    initial begin
        int lat, gaps, lat8, lat24;
        rst = 1'b0; beg = 1'b0; ack = 1'b0; mode = 1'b0; flag = 2'b00;
        x_in = '0; y_in = '0; z_in = '0;
        s_beg = 1'b0; s_ack = 1'b0; s_flag = 2'b00; s_z = '0; s_zero = '0;

        add_vec("rot_z0",      1'b0, 2'b00, 0.0,  0.0,  0.0,        1.0,        0.0,        0.0,        1'b0);
        add_vec("rot_pi6_00",  1'b0, 2'b00, 0.0,  0.0,  PI / 6.0,   0.8660254,  0.5,        0.0,        1'b0);
        add_vec("rot_pi6_11",  1'b0, 2'b11, 0.0,  0.0,  PI / 6.0,  -0.8660254, -0.5,        0.0,        1'b0);
        add_vec("rot_pi6_01",  1'b0, 2'b01, 0.0,  0.0,  PI / 6.0,  -0.8660254,  0.5,        0.0,        1'b0);
        add_vec("rot_pi6_10",  1'b0, 2'b10, 0.0,  0.0,  PI / 6.0,   0.8660254, -0.5,        0.0,        1'b0);
        add_vec("rot_mpi3",    1'b0, 2'b00, 0.0,  0.0, -PI / 3.0,   0.5,       -0.8660254,  0.0,        1'b0);
        add_vec("rot_pi2",     1'b0, 2'b00, 0.0,  0.0,  PI / 2.0,   0.0,        1.0,        0.0,        1'b0);
        add_vec("vec_m05_05",  1'b1, 2'b00, -0.5, 0.5,  0.0,        1.1644354,  0.0,        2.3561945,  1'b1);
        add_vec("vec_03_04",   1'b1, 2'b11, 0.3,  0.4,  0.0,        0.8233801,  0.0,        0.9272952,  1'b1);
        add_vec("vec_m05_0",   1'b1, 2'b00, -0.5, 0.0,  0.0,        0.8233801,  0.0,        PI,         1'b1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_int("rst_ready", int'(ready), 0);
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_x", int'(x_out), 0);
        chk_int("rst_y", int'(y_out), 0);
        chk_int("rst_z", int'(z_out), 0);
        chk_int("rst_ready8", int'(ready8), 0);
        rst = 1'b1;

        // Table-driven vectors
        foreach (vq[i]) begin
            run_op(vq[i].m, vq[i].f, fx(vq[i].x), fx(vq[i].y), fx(vq[i].z), 0, lat, gaps);
            chk_int({vq[i].name, "_lat"}, lat, 19);
            chk_int({vq[i].name, "_busy"}, gaps, 0);
            chk_near({vq[i].name, "_x"}, x_out, vq[i].ex, TOL);
            chk_near({vq[i].name, "_y"}, y_out, vq[i].ey, TOL);
            if (vq[i].cz) chk_near({vq[i].name, "_z"}, z_out, vq[i].ez, TOL);
            do_ack(vq[i].name);
        end

        // Vectoring with ack held low for 10 cycles
        run_op(1'b1, 2'b00, fx(0.6), fx(-0.8), '0, 0, lat, gaps);
        chk_int("hold_lat", lat, 19);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk_int($sformatf("hold_ready_%0d", c), int'(ready), 1);
            chk_near($sformatf("hold_x_%0d", c), x_out, AN, TOL);
            chk_near($sformatf("hold_y_%0d", c), y_out, 0.0, TOL);
            chk_near($sformatf("hold_z_%0d", c), z_out, -0.9272952, TOL);
        end
        do_ack("hold");

        // beg pulsed during ITER must not restart the operation
        run_op(1'b0, 2'b00, '0, '0, fx(PI / 6.0), 5, lat, gaps);
        chk_int("begiter_lat", lat, 19);
        chk_near("begiter_x", x_out, 0.8660254, TOL);
        chk_near("begiter_y", y_out, 0.5, TOL);
        do_ack("begiter");

        // ack and beg together in DONE: back to IDLE, nothing new starts
        run_op(1'b0, 2'b00, '0, '0, '0, 0, lat, gaps);
        chk_int("ackbeg_lat", lat, 19);
        ack = 1'b1; beg = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0; beg = 1'b0;
        chk_int("ackbeg_ready", int'(ready), 0);
        chk_int("ackbeg_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk_int("ackbeg_idle_busy", int'(busy), 0);
        chk_int("ackbeg_idle_ready", int'(ready), 0);

        // Reset asserted during ITER cycle 5 (outputs currently hold ~1.0)
        @(posedge clk); #1;
        mode = 1'b0; flag = 2'b11; z_in = fx(PI / 6.0); beg = 1'b1;
        @(posedge clk); #1;
        beg = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_int("midrst_busy_before", int'(busy), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk_int("midrst_ready", int'(ready), 0);
        chk_int("midrst_busy", int'(busy), 0);
        chk_int("midrst_x", int'(x_out), 0);
        chk_int("midrst_y", int'(y_out), 0);
        chk_int("midrst_z", int'(z_out), 0);

        // Recovery after the aborted operation
        run_op(1'b0, 2'b00, '0, '0, fx(PI / 6.0), 0, lat, gaps);
        chk_int("recover_lat", lat, 19);
        chk_near("recover_x", x_out, 0.8660254, TOL);
        chk_near("recover_y", y_out, 0.5, TOL);
        do_ack("recover");

        // Parameter sweep: ITER=8 and ITER=24, rotation by pi/4
        lat8 = -1; lat24 = -1;
        @(posedge clk); #1;
        s_z = fx(PI / 4.0); s_beg = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (c == 1) s_beg = 1'b0;
            if (ready8 && lat8 < 0) lat8 = c;
            if (ready24 && lat24 < 0) lat24 = c;
            if (lat8 >= 0 && lat24 >= 0) break;
        end
        $display("op sweep lat8=%0d x8=%f y8=%f lat24=%0d x24=%f y24=%f",
                 lat8, rl(x8), rl(y8), lat24, rl(x24), rl(y24));
        chk_int("sweep8_lat", lat8, 11);
        chk_int("sweep24_lat", lat24, 27);
        chk_near("sweep8_x", x8, 0.70710678, 1.0 / 32.0);
        chk_near("sweep8_y", y8, 0.70710678, 1.0 / 32.0);
        chk_near("sweep24_x", x24, 0.70710678, 1.0 / 2097152.0);
        chk_near("sweep24_y", y24, 0.70710678, 1.0 / 2097152.0);
        s_ack = 1'b1;
        @(posedge clk); #1;
        s_ack = 1'b0;
        chk_int("sweep_ack_ready8", int'(ready8), 0);
        chk_int("sweep_ack_ready24", int'(ready24), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
